// File: rtl/fleet_stepper_pkg.sv
// Shared definitions for the alien fleet stepper: state encoding, coordinate
// width and screen-bound defaults also used by the sprite renderer.
package fleet_stepper_pkg;

    localparam int COORD_W = 10;
    localparam int HOLD_W  = 4;
    localparam int CNT_W   = 8;

    localparam int X_MIN_DEF      = 0;
    localparam int X_MAX_DEF      = 639;
    localparam int FLEET_W_DEF    = 320;
    localparam int X_START_DEF    = 160;
    localparam int Y_START_DEF    = 32;
    localparam int STEP_X_DEF     = 8;
    localparam int STEP_Y_DEF     = 16;
    localparam int Y_LIMIT_DEF    = 400;
    localparam int HOLD_TICKS_DEF = 2;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_LANDED = 2'd2
    } fleet_state_t;

endpackage

// File: rtl/fleet_stepper_if.sv
// Move-request inputs and fleet position outputs of the fleet stepper.
interface fleet_stepper_if;
    import fleet_stepper_pkg::*;

    logic              EN;
    logic              M1;
    coord_t            fleet_x;
    coord_t            fleet_y;
    logic              dir;
    logic              step_down;
    logic              landed;
    logic [CNT_W-1:0]  move_cnt;

    modport master (
        output EN, M1,
        input  fleet_x, fleet_y, dir, step_down, landed, move_cnt
    );

    modport slave (
        input  EN, M1,
        output fleet_x, fleet_y, dir, step_down, landed, move_cnt
    );

endinterface

// File: rtl/fleet_stepper_pulse_edge_detect.sv
// Turns a level request into a single-cycle enabled tick on its rising edge.
// A rise seen while en=0 is consumed and never produces a tick.
module pulse_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic lvl,
    output logic tick
);

    logic lvl_q;

    always_ff @(posedge clk) begin
        if (!rst_n) lvl_q <= 1'b0;
        else        lvl_q <= lvl;
    end

    assign tick = lvl & ~lvl_q & en;

endmodule

// File: rtl/fleet_stepper.sv
// Alien fleet position stepper: horizontal moves per tick, descent and
// direction reversal at the screen edges, hold after descent, landing detect.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_RUN    | ticks move the fleet sideways or trigger a descent
//   ST_HOLD   | ticks only count down the post-descent hold
//   ST_LANDED | fleet reached the landing line, frozen until reset
module fleet_stepper
    import fleet_stepper_pkg::*;
#(
    parameter int X_MIN      = X_MIN_DEF,
    parameter int X_MAX      = X_MAX_DEF,
    parameter int FLEET_W    = FLEET_W_DEF,
    parameter int X_START    = X_START_DEF,
    parameter int Y_START    = Y_START_DEF,
    parameter int STEP_X     = STEP_X_DEF,
    parameter int STEP_Y     = STEP_Y_DEF,
    parameter int Y_LIMIT    = Y_LIMIT_DEF,
    parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
    input  logic            CLK,
    input  logic            Rst,
    fleet_stepper_if.slave  bus
);

    localparam logic [COORD_W:0] X_RIGHT_W = (COORD_W+1)'(X_MAX - FLEET_W + 1);
    localparam logic [COORD_W:0] STEP_X_W  = (COORD_W+1)'(STEP_X);
    localparam coord_t           X_LEFT_LO = coord_t'(X_MIN + STEP_X);
    localparam coord_t           STEP_X_C  = coord_t'(STEP_X);
    localparam coord_t           STEP_Y_C  = coord_t'(STEP_Y);
    localparam coord_t           Y_LIMIT_C = coord_t'(Y_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_C   = HOLD_W'(HOLD_TICKS);

    logic              tick;
    fleet_state_t      state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    coord_t            x_q, x_d, y_q, y_d;
    logic              dir_q, dir_d;
    logic              sd_q, sd_d;
    logic              land_q, land_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    coord_t            y_down;

    pulse_edge_detect u_m1_edge (
        .clk   (CLK),
        .rst_n (Rst),
        .en    (bus.EN),
        .lvl   (bus.M1),
        .tick  (tick)
    );

    always_ff @(posedge CLK) begin
        if (!Rst) begin
            state_q <= ST_RUN;
            hold_q  <= '0;
            x_q     <= coord_t'(X_START);
            y_q     <= coord_t'(Y_START);
            dir_q   <= 1'b1;
            sd_q    <= 1'b0;
            land_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            sd_q    <= sd_d;
            land_q  <= land_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y_down = y_q + STEP_Y_C;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        sd_d    = 1'b0;
        land_d  = land_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_RUN: begin
                if (tick) begin
                    if (dir_q && ({1'b0, x_q} + STEP_X_W <= X_RIGHT_W)) begin
                        x_d = x_q + STEP_X_C;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end else if (!dir_q && (x_q >= X_LEFT_LO)) begin
                        x_d = x_q - STEP_X_C;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end else begin
                        y_d   = y_down;
                        dir_d = ~dir_q;
                        sd_d  = 1'b1;
                        if (y_down >= Y_LIMIT_C) begin
                            state_d = ST_LANDED;
                            land_d  = 1'b1;
                        end else if (HOLD_C != '0) begin
                            state_d = ST_HOLD;
                            hold_d  = HOLD_C;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    hold_d = hold_q - 1'b1;
                    if (hold_q == HOLD_W'(1)) state_d = ST_RUN;
                end
            end
            ST_LANDED: begin
                land_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign bus.fleet_x   = x_q;
    assign bus.fleet_y   = y_q;
    assign bus.dir       = dir_q;
    assign bus.step_down = sd_q;
    assign bus.landed    = land_q;
    assign bus.move_cnt  = cnt_q;

endmodule

// File: tb/tb_fleet_stepper.sv
// Self-checking bench for fleet_stepper: per-cycle scoreboard against a
// behavioural model, plus directed checks of edge, hold and landing scenarios.
module tb_fleet_stepper;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       dir;
        logic       sd;
        logic       landed;
        logic [7:0] cnt;
    } out_t;

    logic CLK;
    logic Rst;
    fleet_stepper_if bus();

    fleet_stepper dut (
        .CLK (CLK),
        .Rst (Rst),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    out_t exp_q[$];
    out_t mon_exp, mon_act;

    // behavioural model state
    int m_x, m_y, m_cnt, m_hold;
    bit m_dir, m_sd, m_land, m_prev;

    function automatic out_t model_out();
        out_t o;
        o.x      = 10'(m_x);
        o.y      = 10'(m_y);
        o.dir    = m_dir;
        o.sd     = m_sd;
        o.landed = m_land;
        o.cnt    = 8'(m_cnt);
        return o;
    endfunction

    task automatic model_step(input bit rst_n, input bit en, input bit m1);
        bit t;
        if (!rst_n) begin
            m_x = 160; m_y = 32; m_dir = 1; m_sd = 0; m_land = 0;
            m_cnt = 0; m_hold = 0; m_prev = 0;
            return;
        end
        t = m1 && !m_prev && en;
        m_prev = m1;
        m_sd = 0;
        if (!t || m_land) return;
        if (m_hold > 0) begin
            m_hold--;
        end else if (m_dir && m_x + 8 <= 639 - 320 + 1) begin
            m_x += 8;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end else if (!m_dir && m_x >= 0 + 8) begin
            m_x -= 8;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end else begin
            m_y += 16;
            m_dir = !m_dir;
            m_sd = 1;
            if (m_y >= 400) m_land = 1;
            else            m_hold = 2;
        end
    endtask

    task automatic cycle(input bit rst_n, input bit en, input bit m1);
        @(negedge CLK);
        Rst    = rst_n;
        bus.EN = en;
        bus.M1 = m1;
        model_step(rst_n, en, m1);
        exp_q.push_back(model_out());
        @(posedge CLK);
        #2;
    endtask

    task automatic pulse(input bit en);
        cycle(1, en, 1);
        cycle(1, en, 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " fleet_x"},   int'(bus.fleet_x), 160);
        chk({tag, " fleet_y"},   int'(bus.fleet_y), 32);
        chk({tag, " dir"},       int'(bus.dir), 1);
        chk({tag, " landed"},    int'(bus.landed), 0);
        chk({tag, " move_cnt"},  int'(bus.move_cnt), 0);
        chk({tag, " step_down"}, int'(bus.step_down), 0);
    endtask

    // scoreboard monitor: one expected output word per clock edge
    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act.x      = bus.fleet_x;
            mon_act.y      = bus.fleet_y;
            mon_act.dir    = bus.dir;
            mon_act.sd     = bus.step_down;
            mon_act.landed = bus.landed;
            mon_act.cnt    = bus.move_cnt;
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got x=%0d y=%0d dir=%0d sd=%0d landed=%0d cnt=%0d expected x=%0d y=%0d dir=%0d sd=%0d landed=%0d cnt=%0d",
                         $time, mon_act.x, mon_act.y, mon_act.dir, mon_act.sd, mon_act.landed, mon_act.cnt,
                         mon_exp.x, mon_exp.y, mon_exp.dir, mon_exp.sd, mon_exp.landed, mon_exp.cnt);
            end
        end
    end

    initial begin
        int guard;
        Rst    = 1'b0;
        bus.EN = 1'b0;
        bus.M1 = 1'b0;

        // reset
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk_reset_vals("reset");

        // long M1 high gives exactly one move, visible right after the rise edge
        cycle(1, 1, 1);
        chk("long_m1 x_after_rise", int'(bus.fleet_x), 168);
        chk("long_m1 cnt_after_rise", int'(bus.move_cnt), 1);
        for (int i = 0; i < 4; i++) cycle(1, 1, 1);
        cycle(1, 1, 0);
        chk("long_m1 x_final", int'(bus.fleet_x), 168);
        chk("long_m1 cnt_final", int'(bus.move_cnt), 1);

        // right edge, descent, hold
        cycle(0, 1, 0);
        for (int i = 0; i < 20; i++) pulse(1);
        chk("edge x_at_320", int'(bus.fleet_x), 320);
        chk("edge cnt_20", int'(bus.move_cnt), 20);
        cycle(1, 1, 1);
        chk("edge descent y", int'(bus.fleet_y), 48);
        chk("edge descent dir", int'(bus.dir), 0);
        chk("edge descent step_down", int'(bus.step_down), 1);
        chk("edge descent x", int'(bus.fleet_x), 320);
        cycle(1, 1, 0);
        chk("edge step_down one_cycle", int'(bus.step_down), 0);
        pulse(1);
        pulse(1);
        chk("hold x_frozen", int'(bus.fleet_x), 320);
        chk("hold y_frozen", int'(bus.fleet_y), 48);
        pulse(1);
        chk("after_hold x_left", int'(bus.fleet_x), 312);

        // EN gating, including a rise lost while EN=0
        for (int i = 0; i < 3; i++) pulse(0);
        cycle(1, 0, 1);
        cycle(1, 1, 1);
        cycle(1, 1, 0);
        chk("en_off x_unchanged", int'(bus.fleet_x), 312);
        pulse(1);
        chk("en_on x_moved", int'(bus.fleet_x), 304);

        // landing
        guard = 0;
        while (!m_land && guard < 5000) begin
            pulse(1);
            guard++;
        end
        chk("landing reached_in_budget", int'(guard < 5000), 1);
        chk("landing landed", int'(bus.landed), 1);
        chk("landing y", int'(bus.fleet_y), 400);
        for (int i = 0; i < 5; i++) pulse(1);
        chk("landed frozen y", int'(bus.fleet_y), 400);
        chk("landed frozen landed", int'(bus.landed), 1);
        chk("landed move_cnt saturated", int'(bus.move_cnt), 255);
        cycle(0, 1, 0);
        chk_reset_vals("after_land_reset");

        // reset in the middle of the hold window
        cycle(1, 1, 0);
        for (int i = 0; i < 21; i++) pulse(1);
        pulse(1);
        cycle(0, 1, 0);
        chk_reset_vals("mid_hold_reset");
        pulse(1);
        chk("mid_hold_reset moves_right", int'(bus.fleet_x), 168);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        // drain scoreboard
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge CLK);
            #2;
            guard++;
        end
        chk("scoreboard drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
